// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and shared-memory signals for mem_port_arbiter.
// The slave modport is the arbiter; master is the requester/memory side.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_rdata;

    logic        dm_req;
    logic        dm_rw;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [1:0]  dm_size;
    logic        dm_sign;
    logic        dm_gnt;
    logic        dm_valid;
    logic [31:0] dm_rdata;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rw;
    logic [1:0]  mem_size;
    logic        mem_sign;
    logic [31:0] mem_rdata;

    logic        if_stall;
    logic        dm_stall;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_valid, if_rdata,
        input  dm_req, dm_rw, dm_addr, dm_wdata, dm_size, dm_sign,
        output dm_gnt, dm_valid, dm_rdata,
        output mem_addr, mem_wdata, mem_rw, mem_size, mem_sign,
        input  mem_rdata,
        output if_stall, dm_stall
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_valid, if_rdata,
        output dm_req, dm_rw, dm_addr, dm_wdata, dm_size, dm_sign,
        input  dm_gnt, dm_valid, dm_rdata,
        input  mem_addr, mem_wdata, mem_rw, mem_size, mem_sign,
        output mem_rdata,
        input  if_stall, dm_stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data access onto one single-port memory with
// fixed read latency; data wins unless fetch has been starved STARVE_MAX times.
module mem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic               clock,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);
    localparam int            SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [2:0]    LAT_LOAD   = 3'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

    state_t        state_q, state_d;
    logic [2:0]    lat_q, lat_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          mem_rw_q, mem_rw_d;
    logic [1:0]    mem_size_q, mem_size_d;
    logic          mem_sign_q, mem_sign_d;
    logic          if_valid_q, if_valid_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic          dm_valid_q, dm_valid_d;
    logic [31:0]   dm_rdata_q, dm_rdata_d;
    logic          if_gnt, dm_gnt;

    always_ff @(posedge clock) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (dm_gnt)      state_d = BUSY_DM;
                else if (if_gnt) state_d = BUSY_IF;
            end
            BUSY_IF, BUSY_DM: begin
                if (lat_q == 3'd0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Grants are combinational in IDLE and suppressed while reset is held.
    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (reset && state_q == IDLE) begin
            if (bus.dm_req && !(bus.if_req && starve_q == STARVE_TOP)) dm_gnt = 1'b1;
            else if (bus.if_req)                                     if_gnt = 1'b1;
        end
    end

    always_comb begin
        lat_d       = lat_q;
        starve_d    = starve_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rw_d    = mem_rw_q;
        mem_size_d  = mem_size_q;
        mem_sign_d  = mem_sign_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;

        if (state_q != IDLE) begin
            if (lat_q == 3'd0) begin
                mem_rw_d = 1'b0;
                if (state_q == BUSY_IF) begin
                    if_valid_d = 1'b1;
                    if_rdata_d = bus.mem_rdata;
                end else begin
                    dm_valid_d = 1'b1;
                    dm_rdata_d = mem_rw_q ? 32'd0 : bus.mem_rdata;
                end
            end else begin
                lat_d = lat_q - 3'd1;
            end
        end

        if (dm_gnt) begin
            lat_d       = LAT_LOAD;
            mem_addr_d  = bus.dm_addr;
            mem_wdata_d = bus.dm_wdata;
            mem_rw_d    = bus.dm_rw;
            mem_size_d  = bus.dm_size;
            mem_sign_d  = bus.dm_sign;
        end else if (if_gnt) begin
            lat_d       = LAT_LOAD;
            mem_addr_d  = bus.if_addr;
            mem_rw_d    = 1'b0;
            mem_size_d  = 2'b10;
            mem_sign_d  = 1'b0;
        end

        // Starvation only accumulates while fetch is actually waiting.
        if (if_gnt || !bus.if_req)                  starve_d = '0;
        else if (dm_gnt && starve_q != STARVE_TOP)  starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            lat_q       <= 3'd0;
            starve_q    <= '0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_rw_q    <= 1'b0;
            mem_size_q  <= 2'b00;
            mem_sign_q  <= 1'b0;
            if_valid_q  <= 1'b0;
            if_rdata_q  <= 32'd0;
            dm_valid_q  <= 1'b0;
            dm_rdata_q  <= 32'd0;
        end else begin
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rw_q    <= mem_rw_d;
            mem_size_q  <= mem_size_d;
            mem_sign_q  <= mem_sign_d;
            if_valid_q  <= if_valid_d;
            if_rdata_q  <= if_rdata_d;
            dm_valid_q  <= dm_valid_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.dm_gnt    = dm_gnt;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_valid  = dm_valid_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_rw    = mem_rw_q;
    assign bus.mem_size  = mem_size_q;
    assign bus.mem_sign  = mem_sign_q;
    assign bus.if_stall  = bus.if_req & ~if_valid_q;
    assign bus.dm_stall  = bus.dm_req & ~dm_valid_q;
endmodule
